turn_signal_sequencer: RTL and testbench
========================================

Name: turn_signal_sequencer

Overview:
- Controller for the six-lamp rear-light cluster (three left lamps, three right lamps).
- Divides the system clock into a step tick and latches driver requests (left, right, hazard, brake).
- Arbitrates between simultaneous left/right requests and sequences the lamp patterns one step per tick.
- Sits between the debounced driver-switch inputs and the lamp drivers.

Parameters:
- TICK_DIV, 4, clk cycles per sequence step (legal range 1..65535).
- CNT_W, 16, prescaler counter width; must hold TICK_DIV-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- left_req  in  1  left turn request, level or single-cycle pulse.
- right_req  in  1  right turn request, level or single-cycle pulse.
- hazard  in  1  hazard switch, level.
- brake  in  1  brake pedal, level.
- la, lb, lc  out  1 each  left lamps, inner to outer.
- ra, rb, rc  out  1 each  right lamps, inner to outer.
- busy  out  1  high when the state is not IDLE.
- tick  out  1  one-cycle step strobe (observability).

Behaviour:
- Clocking and reset: clk is the clock. reset is synchronous and active-high, and all state updates on posedge clk.
- Reset values:
  - cnt=0, state=IDLE, pend_l=0, pend_r=0, last=RIGHT (so left wins the first tie).
  - While reset=1, all lamps are forced to 0 regardless of brake. busy=0, tick=0.
- Prescaler:
  - cnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 exactly when cnt==TICK_DIV-1; it is free-running and ignores state.
  - With TICK_DIV=1, tick=1 every cycle.
- Pending flags:
  - pend_l is set on any cycle with left_req=1 and cleared on the edge that enters L1.
  - The same rule applies to pend_r, right_req and R1.
  - Entering HAZ_ON clears both flags.
  - A request in the same cycle as the clear takes priority, so the flag stays set.
- State machine: IDLE, L1, L2, L3, R1, R2, R3, HAZ_ON, HAZ_OFF. Transitions occur only on edges where tick=1; otherwise the state holds.
  - IDLE:
    - hazard goes to HAZ_ON.
    - Otherwise, pend_l and pend_r both set goes to the side opposite to last.
    - Otherwise, pend_l goes to L1; pend_r goes to R1; else stay in IDLE.
    - Entering L1 sets last=LEFT; entering R1 sets last=RIGHT.
  - L1→L2→L3→IDLE and R1→R2→R3→IDLE, unless hazard=1, which goes to HAZ_ON (abort mid-sequence).
  - HAZ_ON→HAZ_OFF→HAZ_ON while hazard=1. If hazard=0, either state goes to IDLE.
  - Pending requests are evaluated only in IDLE. A sequence always returns through IDLE, giving one tick of dark between sequences.
- Lamp decode (Moore, from the state register; changes on the edge after the tick cycle):
  - IDLE: all lamps 0.
  - L1: la=1. L2: la,lb=1. L3: la,lb,lc=1. R1/R2/R3 mirror this on ra/rb/rc.
  - HAZ_ON: all six lamps 1. HAZ_OFF: all six lamps 0.
- Brake override (combinational, does not affect state):
  - When brake=1 in IDLE: all six lamps 1.
  - When brake=1 in L*: right lamps all 1. When brake=1 in R*: left lamps all 1.
  - The sequencing side shows its pattern unchanged.
  - In HAZ_*, brake has no effect.
- Reset mid-sequence: the next edge returns to IDLE and clears pending flags and cnt; no partial pattern remains.
- Simultaneous left_req and right_req pulses in the same cycle set both flags. Arbitration then serves the side opposite to last, followed by the other side.

Test Plan:
- Basic left sequence (TICK_DIV=4):
  - Stimulus: release reset at cycle 0; pulse left_req at cycle 1.
  - Required: tick at cycles 3, 7, 11, 15. la=1 during cycles 4-7; la,lb during 8-11; la,lb,lc during 12-15; all 0 and busy=0 from cycle 16.
- Tie and round-robin:
  - Stimulus: left_req and right_req pulsed together after reset.
  - Required: full L1-L3 sequence, one tick in IDLE, then full R1-R3 sequence. Repeating the tie then serves left first again, since last=RIGHT after the first pair.
- Hazard abort:
  - Stimulus: hazard raised during L2.
  - Required: next tick enters HAZ_ON (all six lamps 1), then alternates 1/0 each step; pend_l=0.
  - Stimulus: drop hazard.
  - Required: IDLE at the next tick.
- Brake:
  - Stimulus: brake=1 in IDLE.
  - Required: all lamps 1.
  - Stimulus: brake=1 during R2.
  - Required: la,lb,lc=1 and ra,rb=1, rc=0.
  - Stimulus: brake=1 during HAZ_OFF.
  - Required: all lamps 0.
- Request while busy:
  - Stimulus: pulse right_req during L1.
  - Required: R1 begins on the tick after the post-L3 IDLE step.
- Reset mid-sequence and TICK_DIV=1:
  - Stimulus: assert reset during R3.
  - Required: all lamps 0 immediately; IDLE, cnt=0 and flags clear after the edge.
  - Stimulus: rerun the basic left test with TICK_DIV=1.
  - Required: a new pattern step every cycle.

Source files
------------

// File: rtl/turn_signal_sequencer.sv
// Six-lamp rear-light sequencer: prescaled step tick, latched left/right requests,
// round-robin arbitration, hazard flashing and a brake overlay on the idle side.
module turn_signal_sequencer #(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic left_req,
  input  logic right_req,
  input  logic hazard,
  input  logic brake,
  output logic la,
  output logic lb,
  output logic lc,
  output logic ra,
  output logic rb,
  output logic rc,
  output logic busy,
  output logic tick
);

  typedef enum logic [3:0] {
    IDLE,
    L1,
    L2,
    L3,
    R1,
    R2,
    R3,
    HAZ_ON,
    HAZ_OFF
  } state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } side_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  state_t           state_reg, state_next;
  side_t            last_reg, last_next;
  logic             pend_l_reg, pend_l_next;
  logic             pend_r_reg, pend_r_next;
  logic             step;
  logic             enter_l1, enter_r1, enter_haz;

  assign step = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg    <= '0;
      state_reg  <= IDLE;
      last_reg   <= RIGHT;
      pend_l_reg <= 1'b0;
      pend_r_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      state_reg  <= state_next;
      last_reg   <= last_next;
      pend_l_reg <= pend_l_next;
      pend_r_reg <= pend_r_next;
    end
  end

  always_comb begin
    cnt_next = step ? '0 : cnt_reg + CNT_W'(1);
  end

  always_comb begin
    state_next = state_reg;
    if (step) begin
      case (state_reg)
        IDLE: begin
          if (hazard)                        state_next = HAZ_ON;
          else if (pend_l_reg && pend_r_reg) state_next = (last_reg == RIGHT) ? L1 : R1;
          else if (pend_l_reg)               state_next = L1;
          else if (pend_r_reg)               state_next = R1;
          else                               state_next = IDLE;
        end
        L1:      state_next = hazard ? HAZ_ON : L2;
        L2:      state_next = hazard ? HAZ_ON : L3;
        L3:      state_next = hazard ? HAZ_ON : IDLE;
        R1:      state_next = hazard ? HAZ_ON : R2;
        R2:      state_next = hazard ? HAZ_ON : R3;
        R3:      state_next = hazard ? HAZ_ON : IDLE;
        HAZ_ON:  state_next = hazard ? HAZ_OFF : IDLE;
        HAZ_OFF: state_next = hazard ? HAZ_ON : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // A request arriving in the same cycle as its clear wins, so it is OR-ed in last.
  always_comb begin
    enter_l1    = (state_next == L1) && (state_reg != L1);
    enter_r1    = (state_next == R1) && (state_reg != R1);
    enter_haz   = (state_next == HAZ_ON) && (state_reg != HAZ_ON);
    last_next   = last_reg;
    if (enter_l1) last_next = LEFT;
    if (enter_r1) last_next = RIGHT;
    pend_l_next = left_req  | (pend_l_reg & ~(enter_l1 | enter_haz));
    pend_r_next = right_req | (pend_r_reg & ~(enter_r1 | enter_haz));
  end

  logic [1:0] left_lvl, right_lvl;
  logic       haz_lit, is_idle, left_seq, right_seq;
  logic [2:0] left_lamp, right_lamp;

  always_comb begin
    left_lvl  = 2'd0;
    right_lvl = 2'd0;
    case (state_reg)
      L1:      left_lvl  = 2'd1;
      L2:      left_lvl  = 2'd2;
      L3:      left_lvl  = 2'd3;
      R1:      right_lvl = 2'd1;
      R2:      right_lvl = 2'd2;
      R3:      right_lvl = 2'd3;
      default: begin
        left_lvl  = 2'd0;
        right_lvl = 2'd0;
      end
    endcase
  end

  assign haz_lit   = (state_reg == HAZ_ON);
  assign is_idle   = (state_reg == IDLE);
  assign left_seq  = (left_lvl != 2'd0);
  assign right_seq = (right_lvl != 2'd0);

  // Lamp gi is lit once the sequence has reached step gi+1; brake fills the non-sequencing side.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lamp
      assign left_lamp[gi]  = ~reset & ((left_lvl > 2'(gi)) | haz_lit |
                                        (brake & (is_idle | right_seq)));
      assign right_lamp[gi] = ~reset & ((right_lvl > 2'(gi)) | haz_lit |
                                        (brake & (is_idle | left_seq)));
    end
  endgenerate

  assign la   = left_lamp[0];
  assign lb   = left_lamp[1];
  assign lc   = left_lamp[2];
  assign ra   = right_lamp[0];
  assign rb   = right_lamp[1];
  assign rc   = right_lamp[2];
  assign busy = ~reset & ~is_idle;
  assign tick = ~reset & step;

endmodule

// File: tb/tb_turn_signal_sequencer.sv
// Bench for turn_signal_sequencer: two instances (TICK_DIV=4 and 1) share stimulus and are
// compared each cycle against a step-counting reference model, plus fixed basic-left timing tables.
module tb_turn_signal_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic left_req = 1'b0;
  logic right_req = 1'b0;
  logic hazard = 1'b0;
  logic brake = 1'b0;

  logic la0, lb0, lc0, ra0, rb0, rc0, busy0, tick0;
  logic la1, lb1, lc1, ra1, rb1, rc1, busy1, tick1;
  logic [7:0] out0, out1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  turn_signal_sequencer #(.TICK_DIV(4), .CNT_W(16)) dut4 (
    .clk(clk), .reset(reset), .left_req(left_req), .right_req(right_req),
    .hazard(hazard), .brake(brake),
    .la(la0), .lb(lb0), .lc(lc0), .ra(ra0), .rb(rb0), .rc(rc0),
    .busy(busy0), .tick(tick0)
  );

  turn_signal_sequencer #(.TICK_DIV(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .left_req(left_req), .right_req(right_req),
    .hazard(hazard), .brake(brake),
    .la(la1), .lb(lb1), .lc(lc1), .ra(ra1), .rb(rb1), .rc(rc1),
    .busy(busy1), .tick(tick1)
  );

  assign out0 = {la0, lb0, lc0, ra0, rb0, rc0, busy0, tick0};
  assign out1 = {la1, lb1, lc1, ra1, rb1, rc1, busy1, tick1};

  // Reference model: mode 0 idle, 1 left run, 2 right run, 3 hazard; pos = lamps lit / flash phase.
  int m_div[2]  = '{4, 1};
  int m_cnt[2]  = '{0, 0};
  int m_mode[2] = '{0, 0};
  int m_pos[2]  = '{0, 0};
  bit m_pl[2]   = '{0, 0};
  bit m_pr[2]   = '{0, 0};
  bit m_last_left[2] = '{0, 0};

  function automatic logic [2:0] bar(int n);
    return {n >= 1, n >= 2, n >= 3};
  endfunction

  function automatic logic [7:0] model_out(int k);
    logic [2:0] lft, rgt;
    logic bsy, tk;
    if (reset) return 8'h00;
    lft = 3'b000;
    rgt = 3'b000;
    if (m_mode[k] == 1) lft = bar(m_pos[k]);
    if (m_mode[k] == 2) rgt = bar(m_pos[k]);
    if (m_mode[k] == 3 && m_pos[k] == 1) begin
      lft = 3'b111;
      rgt = 3'b111;
    end
    if (brake && m_mode[k] != 3) begin
      if (m_mode[k] != 1) lft = 3'b111;
      if (m_mode[k] != 2) rgt = 3'b111;
    end
    bsy = (m_mode[k] != 0);
    tk  = (m_cnt[k] == m_div[k] - 1);
    return {lft, rgt, bsy, tk};
  endfunction

  task automatic model_edge(int k);
    bit t, clr_l, clr_r;
    if (reset) begin
      m_cnt[k] = 0; m_mode[k] = 0; m_pos[k] = 0;
      m_pl[k] = 0; m_pr[k] = 0; m_last_left[k] = 0;
      return;
    end
    t = (m_cnt[k] == m_div[k] - 1);
    m_cnt[k] = t ? 0 : m_cnt[k] + 1;
    clr_l = 0;
    clr_r = 0;
    if (t) begin
      if (hazard && !(m_mode[k] == 3 && m_pos[k] == 1)) begin
        m_mode[k] = 3; m_pos[k] = 1; clr_l = 1; clr_r = 1;
      end else if (m_mode[k] == 3) begin
        if (hazard) m_pos[k] = 0;
        else begin m_mode[k] = 0; m_pos[k] = 0; end
      end else if (m_mode[k] == 1 || m_mode[k] == 2) begin
        if (m_pos[k] < 3) m_pos[k]++;
        else begin m_mode[k] = 0; m_pos[k] = 0; end
      end else if (m_pl[k] && (!m_pr[k] || !m_last_left[k])) begin
        m_mode[k] = 1; m_pos[k] = 1; clr_l = 1; m_last_left[k] = 1;
      end else if (m_pr[k]) begin
        m_mode[k] = 2; m_pos[k] = 1; clr_r = 1; m_last_left[k] = 0;
      end
    end
    m_pl[k] = left_req  | (m_pl[k] & !clr_l);
    m_pr[k] = right_req | (m_pr[k] & !clr_r);
  endtask

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  // Fixed timing for a left pulse at cycle 1 after reset release.
  function automatic logic [7:0] basic4(int c);
    int n;
    n = (c < 4 || c >= 16) ? 0 : c / 4;
    return {bar(n), 3'b000, (c >= 4 && c < 16), (c % 4 == 3)};
  endfunction

  function automatic logic [7:0] basic1(int c);
    int n;
    n = (c >= 3 && c <= 5) ? c - 2 : 0;
    return {bar(n), 3'b000, (c >= 3 && c <= 5), 1'b1};
  endfunction

  task automatic step(input logic rst, input logic l, input logic r, input logic h,
                      input logic b, input int table_c);
    @(negedge clk);
    reset = rst; left_req = l; right_req = r; hazard = h; brake = b;
    #1;
    check("div4_model", out0, model_out(0));
    check("div1_model", out1, model_out(1));
    if (table_c >= 0) begin
      check("div4_basic_left", out0, basic4(table_c));
      check("div1_basic_left", out1, basic1(table_c));
    end
    @(posedge clk);
    model_edge(0);
    model_edge(1);
  endtask

  task automatic hold(int n, logic h, logic b);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, h, b, -1);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
  endtask

  initial begin
    logic l, r, h, b, rst;

    // Basic left sequence, both dividers, against fixed tables.
    do_reset();
    for (int c = 0; c < 22; c++) step(1'b0, c == 1, 1'b0, 1'b0, 1'b0, c);

    // Tie twice: left first both times.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    hold(40, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    hold(40, 1'b0, 1'b0);

    // Hazard raised during L2, held, then dropped.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    hold(9, 1'b0, 1'b0);
    hold(14, 1'b1, 1'b0);
    hold(12, 1'b0, 1'b0);

    // Brake in IDLE, during R2, and during hazard flashing.
    do_reset();
    hold(3, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    hold(9, 1'b0, 1'b0);
    hold(4, 1'b0, 1'b1);
    hold(8, 1'b0, 1'b0);
    hold(16, 1'b1, 1'b1);
    hold(6, 1'b0, 1'b0);

    // Right request while the left sequence is running.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    hold(5, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    hold(34, 1'b0, 1'b0);

    // Reset asserted during R3 with brake on; lamps must go dark at once.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    hold(13, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    hold(12, 1'b0, 1'b0);

    // Randomized traffic.
    h = 1'b0;
    for (int i = 0; i < 700; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      l   = ($urandom_range(0, 7) == 0);
      r   = ($urandom_range(0, 7) == 0);
      if (h) h = ($urandom_range(0, 14) != 0);
      else   h = ($urandom_range(0, 59) == 0);
      b   = ($urandom_range(0, 3) == 0);
      step(rst, l, r, h, b, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
